spi_memory_burst: RTL and testbench
===================================

// Module: spi_memory_burst
// PURPOSE
//   SPI slave fronting an on-chip register memory; next generation of the single-byte
//   SPI memory. Adds parametrised address/data width, depth, clock polarity, multi-word
//   burst transfers with auto-incrementing address, and explicit abort handling.
//   Sits between the board SPI pins and the LED/debug outputs.
// PARAMETERS
//   ADDR_WIDTH  7    address bits in the command frame
//   DATA_WIDTH  8    bits per data word and per memory entry
//   DEPTH       128  implemented words, 1..2**ADDR_WIDTH
//   CPOL        0    0: sample MOSI on SCLK rise, shift MISO on fall; 1: the reverse
// PORTS
//   clk       in   1  system clock; all logic on its rising edge
//   reset     in   1  asynchronous, active-high; returns the FSM to IDLE
//   sclk_pin  in   1  SPI clock, asynchronous to clk
//   cs_pin    in   1  chip select, active low, asynchronous
//   mosi_pin  in   1  serial data in, MSB first
//   miso_pin  out  1  serial data out, MSB first
//   miso_oe   out  1  high while a read data word is being shifted (pad tri-state enable)
//   leds      out  4  low 4 bits of the most recently committed write word
// BEHAVIOUR
// - Reset: miso_pin=0, miso_oe=0, leds=0, state IDLE, counters 0. Memory is NOT cleared.
// - Input conditioning: each pin goes through a 2-flop synchroniser, then an edge
//   detector; internal sample/shift strobes lag the pin edge by 3 clk cycles.
//   Required: SCLK high and low phases each >= 4 clk periods.
// - Frame: CS falling edge -> CMD. Command = ADDR_WIDTH address bits, then 1 R/W bit
//   (1=read), MSB first. Data words of DATA_WIDTH bits follow until CS rises.
// - States: IDLE -(CS low)-> CMD -(last cmd bit, RW=0)-> WRITE;
//   CMD -(last cmd bit, RW=1)-> READ; any state -(CS high)-> IDLE.
// - WRITE: after the DATA_WIDTH-th sample of a word, mem[addr] <= word on the next clk,
//   leds <= word[3:0], addr increments; the bit counter restarts for the next word.
// - READ: on the clk after the last command bit is sampled, shift reg <= mem[addr];
//   miso_oe rises then; MSB drives miso_pin on the first shift edge, later bits on
//   following shift edges. After a word's last bit shifts out, addr increments and
//   the next word reloads before the next shift edge.
// - Address: increments modulo 2**ADDR_WIDTH; DEPTH-1 wraps to 0 when DEPTH is a
//   power of two, else addresses >= DEPTH are unimplemented: writes dropped, reads 0.
// - Abort: CS high mid-command or mid-word discards the partial frame, no memory
//   write, miso_oe=0 on the clk after the synchronised CS edge; completed words
//   remain committed.
// - SCLK edges while CS high are ignored. CS rising and SCLK edge in the same
//   synchronised cycle: CS wins, the edge is discarded.
// - Reset mid-transaction: outputs to reset values immediately; next transaction
//   needs a fresh CS falling edge.
// - miso_pin holds its last value when miso_oe=0; the board drives nothing then.
// TESTING  (ADDR_WIDTH=7, DATA_WIDTH=8, DEPTH=128, CPOL=0 unless stated)
//   1 cmd 0x0A (addr 0x05, write), data 0xA5, CS high -> mem[0x05]=0xA5, leds=4'h5
//   2 cmd 0x0B (addr 0x05, read) -> miso shifts 1010_0101, miso_oe high for 8 SCLK only
//   3 write burst at 0x7F: 0x11,0x22,0x33 -> mem[0x7F]=0x11, mem[0x00]=0x22,
//     mem[0x01]=0x33; read burst from 0x7F returns 0x11,0x22,0x33
//   4 cmd write 0x10, 5 data bits, CS high -> mem[0x10] unchanged, leds unchanged;
//     following full write of 0x3C to 0x10 succeeds
//   5 reset asserted on bit 4 of a read -> miso_oe=0, leds=0 at once; mem[0x05] still 0xA5
//   6 CPOL=1, DEPTH=100: repeat 1-2; write 0x77 to 0x70 then read -> returns 0x00

Source files
------------

// File: rtl/spi_memory_burst_if.sv
// SPI pin bundle for spi_memory_burst: the board-side serial pins plus the
// LED/debug outputs that the memory drives back out.
interface spi_memory_burst_if;
  logic       sclk_pin;
  logic       cs_pin;
  logic       mosi_pin;
  logic       miso_pin;
  logic       miso_oe;
  logic [3:0] leds;

  modport slave (
    input  sclk_pin,
    input  cs_pin,
    input  mosi_pin,
    output miso_pin,
    output miso_oe,
    output leds
  );

  modport master (
    output sclk_pin,
    output cs_pin,
    output mosi_pin,
    input  miso_pin,
    input  miso_oe,
    input  leds
  );
endinterface

// File: rtl/spi_memory_burst.sv
// SPI slave in front of an on-chip word memory. A frame is one command
// (address bits then R/W bit, MSB first) followed by any number of data
// words; the address auto-increments after each word. All pins are
// asynchronous to clk and are synchronised before use.
module spi_memory_burst #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned CPOL       = 0
) (
  input  logic                clk,
  input  logic                reset,
  spi_memory_burst_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMD   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  localparam int unsigned MAXBITS = ((ADDR_WIDTH + 1) > DATA_WIDTH) ? (ADDR_WIDTH + 1) : DATA_WIDTH;
  localparam int unsigned CW      = $clog2(MAXBITS + 1);
  localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          POW2    = ((DEPTH & (DEPTH - 1)) == 0);
  // Power-of-two depths alias/wrap inside the implemented range; others use
  // the full address space and treat the top as unimplemented.
  localparam logic [ADDR_WIDTH-1:0] AMASK   = POW2 ? ADDR_WIDTH'(DEPTH - 1) : '1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic                  SCLK_IDLE = (CPOL != 0);

  // Synchroniser + edge-detect stages
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  logic sclk_rise, sclk_fall, sample_edge, shift_edge;
  logic cs_high, cs_fall, mosi_bit;

  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign sample_edge = (CPOL == 0) ? sclk_rise : sclk_fall;
  assign shift_edge  = (CPOL == 0) ? sclk_fall : sclk_rise;
  assign cs_high     = cs_sync_q[1];
  assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_bit    = mosi_sync_q[1];

  // FSM and datapath state
  logic [1:0]            state_q,  state_d;
  logic [CW-1:0]         cnt_q,    cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [ADDR_WIDTH-1:0] cmd_q,    cmd_d;
  logic [DATA_WIDTH-1:0] wsh_q,    wsh_d;
  logic [DATA_WIDTH-1:0] wword_q,  wword_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  load_q,   load_d;
  logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
  logic                  miso_q,   miso_d;
  logic                  oe_q,     oe_d;
  logic [3:0]            leds_q,   leds_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]         idx;
  logic                  mem_ok;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign idx      = IW'(addr_q);
  assign mem_ok   = POW2 || ({1'b0, addr_q} < DEPTH_L);
  assign rdata    = mem_ok ? mem_q[idx] : '0;
  assign addr_inc = (addr_q + ADDR_WIDTH'(1)) & AMASK;

  // Bring the asynchronous pins into the clk domain (CS resets to "asserted"
  // so a CS held low across reset never looks like a fresh falling edge)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= {3{SCLK_IDLE}};
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk_pin};
      cs_sync_q   <= {cs_sync_q[1:0], bus.cs_pin};
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi_pin};
    end
  end

  // Next-state logic: command decode, write assembly, read shifting, abort
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    wsh_d     = wsh_q;
    wword_d   = wword_q;
    wr_pend_d = 1'b0;
    load_d    = 1'b0;
    shreg_d   = shreg_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    leds_d    = leds_q;

    // Commit of a completed write word, one clk after its last sample
    if (wr_pend_q) begin
      if (mem_ok) leds_d = wword_q[3:0];
      addr_d = addr_inc;
    end

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        if (sample_edge) begin
          if (cnt_q == CW'(ADDR_WIDTH)) begin
            addr_d  = cmd_q & AMASK;
            cnt_d   = '0;
            state_d = mosi_bit ? S_READ : S_WRITE;
            load_d  = mosi_bit;
          end else begin
            cmd_d = {cmd_q[ADDR_WIDTH-2:0], mosi_bit};
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WRITE: begin
        if (sample_edge) begin
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            wword_d   = {wsh_q[DATA_WIDTH-2:0], mosi_bit};
            wr_pend_d = 1'b1;
            cnt_d     = '0;
          end else begin
            wsh_d = {wsh_q[DATA_WIDTH-2:0], mosi_bit};
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        if (load_q) begin
          shreg_d = rdata;
          oe_d    = 1'b1;
        end else if (shift_edge) begin
          miso_d  = shreg_q[DATA_WIDTH-1];
          shreg_d = shreg_q << 1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d  = '0;
            addr_d = addr_inc;
            load_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase

    // CS deasserted overrides everything, including a coincident SCLK edge
    if (cs_high) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      oe_d      = 1'b0;
      load_d    = 1'b0;
      wr_pend_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      cmd_q     <= '0;
      wsh_q     <= '0;
      wword_q   <= '0;
      wr_pend_q <= 1'b0;
      load_q    <= 1'b0;
      shreg_q   <= '0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      leds_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      wsh_q     <= wsh_d;
      wword_q   <= wword_d;
      wr_pend_q <= wr_pend_d;
      load_q    <= load_d;
      shreg_q   <= shreg_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      leds_q    <= leds_d;
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_pend_q && mem_ok) mem_q[idx] <= wword_q;
  end

  assign bus.miso_pin = miso_q;
  assign bus.miso_oe  = oe_q;
  assign bus.leds     = leds_q;

endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench for spi_memory_burst: a CPOL=0/DEPTH=128 instance and a
// CPOL=1/DEPTH=100 instance, each driven by a bit-banged SPI master.
module tb_spi_memory_burst;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       sclk_v [2];
  logic       cs_v   [2];
  logic       mosi_v [2];
  logic       miso_w [2];
  logic       oe_w   [2];
  logic [3:0] leds_w [2];

  int checks = 0;
  int failures = 0;

  spi_memory_burst_if bus0();
  spi_memory_burst_if bus1();

  assign bus0.sclk_pin = sclk_v[0];
  assign bus0.cs_pin   = cs_v[0];
  assign bus0.mosi_pin = mosi_v[0];
  assign bus1.sclk_pin = sclk_v[1];
  assign bus1.cs_pin   = cs_v[1];
  assign bus1.mosi_pin = mosi_v[1];
  assign miso_w[0] = bus0.miso_pin;
  assign miso_w[1] = bus1.miso_pin;
  assign oe_w[0]   = bus0.miso_oe;
  assign oe_w[1]   = bus1.miso_oe;
  assign leds_w[0] = bus0.leds;
  assign leds_w[1] = bus1.leds;

  spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .DEPTH(128), .CPOL(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .DEPTH(100), .CPOL(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  // One SCLK period: drive MOSI, sample MISO just before the sample edge
  task automatic spi_bit(input int d, input logic bo, output logic bi);
    logic cp;
    cp = (d == 1);
    mosi_v[d] = bo;
    #HALF;
    bi = miso_w[d];
    sclk_v[d] = ~cp;
    #HALF;
    sclk_v[d] = cp;
  endtask

  task automatic cs_begin(input int d);
    cs_v[d] = 1'b0;
    #HALF;
  endtask

  task automatic cs_end(input int d);
    #HALF;
    cs_v[d] = 1'b1;
    #(2*HALF);
  endtask

  task automatic send_cmd(input int d, input logic [6:0] a, input logic rw);
    logic [7:0] c;
    logic b;
    c = {a, rw};
    for (int i = 7; i >= 0; i--) spi_bit(d, c[i], b);
  endtask

  task automatic xfer_word(input int d, input logic [7:0] wo, output logic [7:0] wi);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d, wo[i], b);
      wi[i] = b;
    end
  endtask

  task automatic do_write(input int d, input logic [6:0] a, input int n, input logic [23:0] w);
    logic [7:0] dummy;
    cs_begin(d);
    send_cmd(d, a, 1'b0);
    for (int k = 0; k < n; k++) xfer_word(d, w[23-8*k -: 8], dummy);
    cs_end(d);
  endtask

  task automatic do_read(input int d, input logic [6:0] a, input int n, output logic [23:0] r);
    logic [7:0] wi;
    r = '0;
    cs_begin(d);
    send_cmd(d, a, 1'b1);
    for (int k = 0; k < n; k++) begin
      xfer_word(d, 8'h00, wi);
      r[23-8*k -: 8] = wi;
    end
    cs_end(d);
  endtask

  task automatic test_reset();
    #23;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (miso_w[d] !== 1'b0) begin failures++; $display("FAIL reset_miso dut%0d got=%b exp=0", d, miso_w[d]); end
      checks++;
      if (oe_w[d] !== 1'b0) begin failures++; $display("FAIL reset_oe dut%0d got=%b exp=0", d, oe_w[d]); end
      checks++;
      if (leds_w[d] !== 4'h0) begin failures++; $display("FAIL reset_leds dut%0d got=%h exp=0", d, leds_w[d]); end
    end
    reset = 1'b0;
    #100;
  endtask

  task automatic test_single(input int d);
    logic [7:0] wi;
    do_write(d, 7'h05, 1, 24'hA50000);
    checks++;
    if (leds_w[d] !== 4'h5) begin failures++; $display("FAIL single_write_leds dut%0d got=%h exp=5", d, leds_w[d]); end
    cs_begin(d);
    checks++;
    if (oe_w[d] !== 1'b0) begin failures++; $display("FAIL oe_before_cmd dut%0d got=%b exp=0", d, oe_w[d]); end
    send_cmd(d, 7'h05, 1'b1);
    checks++;
    if (oe_w[d] !== 1'b1) begin failures++; $display("FAIL oe_after_cmd dut%0d got=%b exp=1", d, oe_w[d]); end
    xfer_word(d, 8'h00, wi);
    checks++;
    if (wi !== 8'hA5) begin failures++; $display("FAIL single_read dut%0d got=%h exp=a5", d, wi); end
    checks++;
    if (oe_w[d] !== 1'b1) begin failures++; $display("FAIL oe_end_word dut%0d got=%b exp=1", d, oe_w[d]); end
    cs_end(d);
    checks++;
    if (oe_w[d] !== 1'b0) begin failures++; $display("FAIL oe_after_cs dut%0d got=%b exp=0", d, oe_w[d]); end
  endtask

  task automatic test_burst_wrap();
    logic [23:0] r;
    do_write(0, 7'h7F, 3, 24'h112233);
    checks++;
    if (leds_w[0] !== 4'h3) begin failures++; $display("FAIL burst_leds got=%h exp=3", leds_w[0]); end
    do_read(0, 7'h7F, 3, r);
    checks++;
    if (r !== 24'h112233) begin failures++; $display("FAIL burst_read got=%h exp=112233", r); end
    do_read(0, 7'h00, 1, r);
    checks++;
    if (r[23:16] !== 8'h22) begin failures++; $display("FAIL wrap_addr0 got=%h exp=22", r[23:16]); end
  endtask

  task automatic test_abort_word();
    logic [23:0] r;
    logic [4:0] part;
    logic b;
    do_write(0, 7'h10, 1, 24'h990000);
    part = 5'b11110;
    cs_begin(0);
    send_cmd(0, 7'h10, 1'b0);
    for (int i = 4; i >= 0; i--) spi_bit(0, part[i], b);
    cs_end(0);
    checks++;
    if (leds_w[0] !== 4'h9) begin failures++; $display("FAIL abort_leds got=%h exp=9", leds_w[0]); end
    do_read(0, 7'h10, 1, r);
    checks++;
    if (r[23:16] !== 8'h99) begin failures++; $display("FAIL abort_mem got=%h exp=99", r[23:16]); end
    do_write(0, 7'h10, 1, 24'h3C0000);
    checks++;
    if (leds_w[0] !== 4'hC) begin failures++; $display("FAIL after_abort_leds got=%h exp=c", leds_w[0]); end
    do_read(0, 7'h10, 1, r);
    checks++;
    if (r[23:16] !== 8'h3C) begin failures++; $display("FAIL after_abort_mem got=%h exp=3c", r[23:16]); end
  endtask

  task automatic test_abort_cmd();
    logic [23:0] r;
    logic b;
    cs_begin(0);
    for (int i = 0; i < 4; i++) spi_bit(0, 1'b1, b);
    cs_end(0);
    checks++;
    if (oe_w[0] !== 1'b0) begin failures++; $display("FAIL abort_cmd_oe got=%b exp=0", oe_w[0]); end
    do_read(0, 7'h05, 1, r);
    checks++;
    if (r[23:16] !== 8'hA5) begin failures++; $display("FAIL abort_cmd_mem got=%h exp=a5", r[23:16]); end
  endtask

  task automatic test_reset_mid_read();
    logic [23:0] r;
    logic b;
    cs_begin(0);
    send_cmd(0, 7'h05, 1'b1);
    for (int i = 0; i < 4; i++) spi_bit(0, 1'b0, b);
    reset = 1'b1;
    #1;
    checks++;
    if (oe_w[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_oe got=%b exp=0", oe_w[0]); end
    checks++;
    if (leds_w[0] !== 4'h0) begin failures++; $display("FAIL rst_mid_leds got=%h exp=0", leds_w[0]); end
    checks++;
    if (miso_w[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_miso got=%b exp=0", miso_w[0]); end
    #29;
    reset = 1'b0;
    // CS still low: without a fresh falling edge no read may start
    send_cmd(0, 7'h05, 1'b1);
    checks++;
    if (oe_w[0] !== 1'b0) begin failures++; $display("FAIL no_fresh_cs_oe got=%b exp=0", oe_w[0]); end
    cs_end(0);
    do_read(0, 7'h05, 1, r);
    checks++;
    if (r[23:16] !== 8'hA5) begin failures++; $display("FAIL rst_mem_kept got=%h exp=a5", r[23:16]); end
  endtask

  task automatic test_cpol1_depth100();
    logic [23:0] r;
    test_single(1);
    do_write(1, 7'h70, 1, 24'h770000);
    checks++;
    if (leds_w[1] !== 4'h5) begin failures++; $display("FAIL unimpl_leds got=%h exp=5", leds_w[1]); end
    do_read(1, 7'h70, 1, r);
    checks++;
    if (r[23:16] !== 8'h00) begin failures++; $display("FAIL unimpl_read got=%h exp=00", r[23:16]); end
  endtask

  initial begin
    sclk_v[0] = 1'b0;
    sclk_v[1] = 1'b1;
    cs_v[0]   = 1'b1;
    cs_v[1]   = 1'b1;
    mosi_v[0] = 1'b0;
    mosi_v[1] = 1'b0;
    test_reset();
    test_single(0);
    test_burst_wrap();
    test_abort_word();
    test_abort_cmd();
    test_reset_mid_read();
    test_cpol1_depth100();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
